// File: rtl/rvfi_wb_responder.sv
// Multi-channel Wishbone-classic responder for core test harnesses: stall-controlled ack latency, external read data, sticky protocol-violation flag.
// Optional bounded-wait fairness (forced response after MAX_WAIT stalled cycles) is enabled by defining RVFI_WB_FAIRNESS_EN.
module rvfi_wb_responder #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 7
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NCH-1:0]        i_cyc,
  input  logic [NCH*AW-1:0]     i_adr,
  input  logic [NCH-1:0]        i_we,
  input  logic [NCH*DW/8-1:0]   i_sel,
  input  logic [NCH*DW-1:0]     i_dat,
  output logic [NCH-1:0]        o_ack,
  output logic [NCH*DW-1:0]     o_rdt,
  input  logic [NCH-1:0]        i_stall,
  input  logic [NCH*DW-1:0]     i_rdata,
  output logic [NCH-1:0]        o_err,
  output logic [NCH-1:0]        o_busy
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   adr_q;
    logic            we_q;
    logic [SW-1:0]   sel_q;
    logic [DW-1:0]   dat_q;
    logic            ack_q;
    logic            busy_q;
    logic            err_q;
    logic [DW-1:0]   rdt_q;

    logic [AW-1:0]   adr;
    logic [SW-1:0]   sel;
    logic [DW-1:0]   dat;
    logic [DW-1:0]   rdata;
    logic            mismatch_c;
    logic            force_c;

    assign adr   = i_adr[c*AW +: AW];
    assign sel   = i_sel[c*SW +: SW];
    assign dat   = i_dat[c*DW +: DW];
    assign rdata = i_rdata[c*DW +: DW];

    // Master must hold the request stable until ack; write data only matters for writes.
    assign mismatch_c = (adr != adr_q) || (i_we[c] != we_q) || (sel != sel_q) ||
                        (we_q && (dat != dat_q));

`ifdef RVFI_WB_FAIRNESS_EN
    assign force_c = (cnt_q == CW'(MAX_WAIT - 1));
`else
    assign force_c = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        adr_q   <= '0;
        we_q    <= 1'b0;
        sel_q   <= '0;
        dat_q   <= '0;
        ack_q   <= 1'b0;
        busy_q  <= 1'b0;
        err_q   <= 1'b0;
        rdt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            ack_q <= 1'b0;
            if (i_cyc[c]) begin
              adr_q   <= adr;
              we_q    <= i_we[c];
              sel_q   <= sel;
              dat_q   <= dat;
              cnt_q   <= '0;
              state_q <= ST_WAIT;
              busy_q  <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (!i_cyc[c]) begin
              // Abort takes priority over a simultaneous release of stall.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              if (mismatch_c) begin
                err_q <= 1'b1;
              end
              if (!i_stall[c] || force_c) begin
                state_q <= ST_RESP;
                ack_q   <= 1'b1;
                rdt_q   <= we_q ? '0 : rdata;
              end else if (cnt_q != CW'(MAX_WAIT)) begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          ST_RESP: begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end

`ifdef RVFI_WB_FAIRNESS_EN
    // Forced response must fire before the wait counter can saturate.
    always_ff @(posedge clock) begin
      if (resetn && (state_q == ST_WAIT)) begin
        assert (cnt_q != CW'(MAX_WAIT));
      end
    end
`endif

    assign o_ack[c]          = ack_q;
    assign o_busy[c]         = busy_q;
    assign o_err[c]          = err_q;
    assign o_rdt[c*DW +: DW] = rdt_q;
  end

endmodule

// File: tb/tb_rvfi_wb_responder.sv
// Directed bench for rvfi_wb_responder: table-driven single-channel vectors plus hand-written abort, fairness, violation and reset sequences.
module tb_rvfi_wb_responder;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic                clock;
  logic                resetn;
  logic [NCH-1:0]      cyc;
  logic [NCH*AW-1:0]   adr;
  logic [NCH-1:0]      we;
  logic [NCH*DW/8-1:0] sel;
  logic [NCH*DW-1:0]   dat;
  logic [NCH-1:0]      ack;
  logic [NCH*DW-1:0]   rdt;
  logic [NCH-1:0]      stall;
  logic [NCH*DW-1:0]   rdata;
  logic [NCH-1:0]      err;
  logic [NCH-1:0]      busy;

  int checks = 0;
  int errors = 0;

  rvfi_wb_responder #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_WAIT(7)) dut (
    .clock  (clock),
    .resetn (resetn),
    .i_cyc  (cyc),
    .i_adr  (adr),
    .i_we   (we),
    .i_sel  (sel),
    .i_dat  (dat),
    .o_ack  (ack),
    .o_rdt  (rdt),
    .i_stall(stall),
    .i_rdata(rdata),
    .o_err  (err),
    .o_busy (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          ch;
    logic        cyc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        stall;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;
    logic [31:0] rdt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input int ch, input logic c, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic s, input logic [31:0] r);
    cyc[ch]             = c;
    we[ch]              = w;
    adr[ch*AW +: AW]    = a;
    sel[ch*4 +: 4]      = 4'hF;
    dat[ch*DW +: DW]    = d;
    stall[ch]           = s;
    rdata[ch*DW +: DW]  = r;
  endtask

  function automatic logic [31:0] rdt_of(input int ch);
    return rdt[ch*DW +: DW];
  endfunction

  initial begin
    int acks;
    int first;

    tbl[0]  = '{0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{0, 1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1, 1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{1, 1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D};
    tbl[5]  = '{1, 1'b0, 1'b0, 32'h200, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D};
    tbl[6]  = '{1, 1'b1, 1'b1, 32'h300, 32'h12345678, 1'b1, 32'hAAAA5555, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D};
    for (int i = 7; i <= 10; i++)
      tbl[i] = '{1, 1'b1, 1'b1, 32'h300, 32'h12345678, 1'b1, 32'hAAAA5555, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D};
    tbl[11] = '{1, 1'b1, 1'b1, 32'h300, 32'h12345678, 1'b0, 32'hAAAA5555, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[12] = '{1, 1'b0, 1'b0, 32'h300, 32'h0,        1'b0, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 32'h0};

    resetn = 1'b0;
    cyc = '0; adr = '0; we = '0; sel = '0; dat = '0; stall = '0; rdata = '0;
    tick();
    chk("reset_ack",  32'(ack),  32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_err",  32'(err),  32'h0);
    chk("reset_rdt0", rdt_of(0), 32'h0);
    chk("reset_rdt1", rdt_of(1), 32'h0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ch, tbl[i].cyc, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].stall, tbl[i].rdata);
      tick();
      chk($sformatf("vec%0d_ack", i),  32'(ack[tbl[i].ch]),  32'(tbl[i].ack));
      chk($sformatf("vec%0d_busy", i), 32'(busy[tbl[i].ch]), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_err", i),  32'(err[tbl[i].ch]),  32'(tbl[i].err));
      chk($sformatf("vec%0d_rdt", i),  rdt_of(tbl[i].ch),    tbl[i].rdt);
    end

    // Abort with simultaneous stall release, then a normal request right after.
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h11112222);
    tick();
    chk("abort_wait_busy", 32'(busy[0]), 32'h1);
    drive(0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h11112222);
    tick();
    chk("abort_ack",  32'(ack[0]),  32'h0);
    chk("abort_busy", 32'(busy[0]), 32'h0);
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h11112222);
    tick();
    chk("abort_next_ack0", 32'(ack[0]), 32'h0);
    tick();
    chk("abort_next_ack1", 32'(ack[0]), 32'h1);
    chk("abort_next_rdt",  rdt_of(0),   32'h11112222);
    drive(0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    tick();
    chk("abort_next_idle", 32'(busy[0]), 32'h0);

    // Stall held high indefinitely.
    drive(0, 1'b1, 1'b0, 32'h180, 32'h0, 1'b1, 32'h77778888);
    acks = 0;
    first = -1;
`ifdef RVFI_WB_FAIRNESS_EN
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ack[0]) begin
        acks++;
        if (first < 0) first = k;
        cyc[0] = 1'b0;
      end
    end
    chk("fair_ack_count", 32'(acks),  32'd1);
    chk("fair_ack_tick",  32'(first), 32'd8);
    chk("fair_rdt",       rdt_of(0),  32'h77778888);
`else
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (ack[0]) acks++;
    end
    chk("nofair_ack_count", 32'(acks),                 32'd0);
    chk("nofair_busy",      32'(busy[0]),              32'h1);
    chk("nofair_cnt_sat",   32'(dut.g_ch[0].cnt_q),    32'd7);
    cyc[0] = 1'b0;
    tick();
`endif
    stall[0] = 1'b0;
    tick();
    chk("stall_seq_idle", 32'(busy[0]), 32'h0);

    // Violation on ch0 while ch1 runs back-to-back zero-stall reads.
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'h5A5A0001);
    tick();
    chk("viol_err0_pre", 32'(err[0]), 32'h0);
    adr[0 +: AW] = 32'h104;
    tick();
    chk("viol_err0_set", 32'(err[0]), 32'h1);
    chk("viol_ch1_ack",  32'(ack[1]), 32'h1);
    chk("viol_ch1_rdt",  rdt_of(1),   32'h5A5A0001);
    rdata[DW +: DW] = 32'h5A5A0002;
    tick();
    chk("b2b_ch1_idle",  32'(busy[1]), 32'h0);
    tick();
    chk("b2b_ch1_wait",  32'(ack[1]),  32'h0);
    tick();
    chk("b2b_ch1_ack",   32'(ack[1]),  32'h1);
    chk("b2b_ch1_rdt",   rdt_of(1),    32'h5A5A0002);
    chk("viol_err1",     32'(err[1]),  32'h0);
    chk("viol_ch0_busy", 32'(busy[0]), 32'h1);
    cyc[1]   = 1'b0;
    stall[0] = 1'b0;
    tick();
    chk("viol_ch0_ack",  32'(ack[0]),  32'h1);
    cyc[0] = 1'b0;
    tick();
    drive(0, 1'b1, 1'b0, 32'h108, 32'h0, 1'b0, 32'h0BADF00D);
    tick();
    tick();
    chk("sticky_ack",  32'(ack[0]), 32'h1);
    chk("sticky_err0", 32'(err[0]), 32'h1);
    chk("sticky_err1", 32'(err[1]), 32'h0);
    cyc[0] = 1'b0;
    tick();

    // Asynchronous reset in the middle of a stalled wait.
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0);
    repeat (3) tick();
    chk("rst_pre_busy", 32'(busy[0]), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_ack",  32'(ack[0]),  32'h0);
    chk("rst_async_busy", 32'(busy[0]), 32'h0);
    chk("rst_async_err",  32'(err[0]),  32'h0);
    cyc[0] = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    tick();
    tick();
    chk("rst_post_busy", 32'(busy[0]), 32'h0);
    chk("rst_post_ack",  32'(ack[0]),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvfi_wb_responder.md
Name: rvfi_wb_responder

Overview:
- Parametrised, multi-channel Wishbone-classic responder model for formal and simulation harnesses around RISC-V cores under test.
- Replaces hand-written per-bus assume blocks with one reusable block per harness.
- Per channel:
  - generates ack with solver/bench-controlled latency;
  - returns externally supplied read data;
  - bounds wait time when fairness is enabled;
  - flags master-side protocol violations.

Parameters:
- NCH, 2, number of independent bus channels (e.g. ibus, dbus).
- AW, 32, address width.
- DW, 32, data width; DW/8 select lanes.
- MAX_WAIT, 7, maximum cycles a channel stays in WAIT before a forced response (only used with fairness); legal range 1..255.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- i_cyc  in  NCH  per-channel cycle/strobe from master.
- i_adr  in  NCH*AW  per-channel address, channel c at bits [c*AW +: AW].
- i_we  in  NCH  write enable.
- i_sel  in  NCH*DW/8  byte selects.
- i_dat  in  NCH*DW  write data.
- o_ack  out  NCH  acknowledge, one-cycle pulse.
- o_rdt  out  NCH*DW  read data, valid while o_ack.
- i_stall  in  NCH  nondeterministic stall request (solver rand reg or bench).
- i_rdata  in  NCH*DW  nondeterministic read data source.
- o_err  out  NCH  sticky protocol-violation flag.
- o_busy  out  NCH  channel in WAIT or RESP.

Behaviour:
- Reset (resetn=0, async): all channels IDLE; o_ack=0, o_rdt=0, o_err=0, o_busy=0, wait counters 0, latched request 0. Effect is immediate and independent of clock. Deassertion is synchronous to clock in the harness.
- Channels are fully independent; no shared state or arbitration.
- Per-channel FSM, states IDLE, WAIT, RESP:
  - IDLE: on edge with i_cyc=1, latch adr/we/sel/dat, cnt<=0, go WAIT. Otherwise stay.
  - WAIT:
    - If i_cyc=0 → IDLE (abort, no ack ever issued for it).
    - Else if i_stall=0 → RESP; capture o_rdt<=i_rdata if latched we=0, else o_rdt<=0.
    - Else cnt<=cnt+1, saturating at MAX_WAIT.
  - RESP: o_ack=1 for exactly this cycle. Next edge → IDLE, o_ack=0, o_rdt held until the next RESP (do not clear).
- o_ack is registered; o_ack=1 iff state==RESP. Never asserted while in IDLE.
- Minimum latency: i_cyc first sampled high at edge t → o_ack high in the cycle after edge t+1.
- Back-to-back: a master keeping i_cyc=1 after ack is sampled in IDLE on the edge after RESP. Issue-to-issue spacing is 3 cycles minimum.
- Violation detection, in WAIT with i_cyc=1:
  - Sets o_err if i_adr, i_we or i_sel differ from the latched values.
  - Also sets it if latched we=1 and i_dat differs.
  - o_err stays set until reset.
  - Detection does not alter FSM progress.
- Simultaneous i_cyc drop and i_stall=0 in WAIT: abort wins → IDLE, no ack.
- cnt width = $clog2(MAX_WAIT+1); no wrap-around.
- o_busy = (state != IDLE).

Optional Feature:
- Macro RVFI_WB_FAIRNESS_EN.
- Defined:
  - In WAIT with i_cyc=1 and cnt==MAX_WAIT-1, i_stall is ignored and the channel moves to RESP. Guarantees ack at most MAX_WAIT+1 cycles after the request is sampled.
  - Adds an assertion that cnt never reaches MAX_WAIT while in WAIT.
- Undefined:
  - i_stall may hold a channel in WAIT indefinitely.
  - cnt still counts and saturates (observable for coverage only).
  - No forced response.

Test Plan:
- Reset mid-WAIT: ch0 i_cyc=1, i_stall=1 for 3 cycles, then resetn=0 → o_ack=0, o_busy=0 immediately; after release with i_cyc=0, ch0 stays IDLE.
- Zero-stall read: ch0 i_cyc=1, i_we=0, i_adr=0x100, i_stall=0, i_rdata=0xDEADBEEF → o_ack pulses one cycle two edges after the request is sampled, o_rdt=0xDEADBEEF; o_err=0.
- Write with stall: ch1 i_we=1, i_dat=0x12345678, i_stall=1 for 4 cycles then 0 → o_ack one cycle later, o_rdt=0, no ack during stall.
- Fairness, macro on, MAX_WAIT=7: ch0 request with i_stall held 1 forever → o_ack asserted exactly once, 8 edges after the request is sampled. Macro off, same stimulus → no ack for 50 cycles, cnt saturated at 7.
- Abort: ch0 in WAIT, i_cyc drops the same cycle i_stall=0 → no o_ack, back to IDLE; new request next cycle is accepted normally.
- Violation plus independence: ch0 in WAIT, i_adr changes 0x100→0x104 → o_err[0]=1 and stays 1 through later transactions. Ch1 runs concurrent zero-stall reads with o_err[1]=0 and unaffected ack timing.
